// File: rtl/perceptron_sequencer.sv
// Two-input perceptron sequencer: owns weights/inputs, time-shares one registered
// signed multiplier, applies the step activation and an optional learning update.
module perceptron_sequencer #(
  parameter int FRAC_BITS  = 8,
  parameter int RATE_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        weight_write_i,
  input  logic [15:0] weight1_new_i,
  input  logic [15:0] weight2_new_i,
  input  logic        input_write_i,
  input  logic [15:0] data_in1_i,
  input  logic [15:0] data_in2_i,
  input  logic        learn_en_i,
  input  logic        target_i,
  output logic [15:0] mul_a_o,
  output logic [15:0] mul_b_o,
  input  logic [31:0] mul_p_i,
  output logic [15:0] weight1_o,
  output logic [15:0] weight2_o,
  output logic [15:0] result_o,
  output logic        activation_o,
  output logic        result_valid_o,
  output logic        busy_o,
  output logic        overrun_o
);

  typedef enum logic [2:0] {IDLE, MUL1, MUL2, ACC, ACT, UPD, DONE} state_e;

  state_e             state_q, state_d;
  logic [15:0]        w1_q, w1_d, w2_q, w2_d;
  logic [15:0]        x1_q, x1_d, x2_q, x2_d;
  logic               learnEn_q, learnEn_d, target_q, target_d;
  logic [31:0]        prod1_q, prod1_d;
  logic signed [32:0] sum_q, sum_d;
  logic [15:0]        result_q, result_d;
  logic               act_q, act_d;
  logic               overrun_q, overrun_d;
  logic               pendValid_q, pendValid_d;
  logic [15:0]        pendW1_q, pendW1_d, pendW2_q, pendW2_d;

  logic signed [32:0] sumFull;
  logic [15:0]        clampVal;
  logic signed [15:0] delta1, delta2;
  logic [16:0]        upd1Wide, upd2Wide;

  function automatic logic [15:0] clampSum(input logic [32:0] v);
    if (&v[32:15] || ~|v[32:15]) return v[15:0];
    return v[32] ? 16'h8000 : 16'h7FFF;
  endfunction

  function automatic logic [15:0] sat17(input logic [16:0] v);
    if (v[16] != v[15]) return v[16] ? 16'h8000 : 16'h7FFF;
    return v[15:0];
  endfunction

  always_comb begin
    sumFull  = $signed({prod1_q[31], prod1_q}) + $signed({mul_p_i[31], mul_p_i});
    clampVal = clampSum(sum_q);
    delta1   = $signed(x1_q) >>> RATE_SHIFT;
    delta2   = $signed(x2_q) >>> RATE_SHIFT;
    upd1Wide = target_q ? ({w1_q[15], w1_q} + {delta1[15], delta1})
                        : ({w1_q[15], w1_q} - {delta1[15], delta1});
    upd2Wide = target_q ? ({w2_q[15], w2_q} + {delta2[15], delta2})
                        : ({w2_q[15], w2_q} - {delta2[15], delta2});
  end

  always_comb begin
    state_d     = state_q;
    w1_d        = w1_q;
    w2_d        = w2_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    learnEn_d   = learnEn_q;
    target_d    = target_q;
    prod1_d     = prod1_q;
    sum_d       = sum_q;
    result_d    = result_q;
    act_d       = act_q;
    overrun_d   = overrun_q;
    pendValid_d = pendValid_q;
    pendW1_d    = pendW1_q;
    pendW2_d    = pendW2_q;

    unique case (state_q)
      IDLE: begin
        if (weight_write_i) begin
          w1_d = weight1_new_i;
          w2_d = weight2_new_i;
        end
        if (input_write_i) begin
          x1_d      = data_in1_i;
          x2_d      = data_in2_i;
          learnEn_d = learn_en_i;
          target_d  = target_i;
          overrun_d = 1'b0;
          state_d   = MUL1;
        end
      end
      MUL1: state_d = MUL2;
      MUL2: begin
        prod1_d = mul_p_i;
        state_d = ACC;
      end
      ACC: begin
        sum_d   = sumFull >>> FRAC_BITS;
        state_d = ACT;
      end
      ACT: begin
        result_d = clampVal;
        act_d    = ~clampVal[15];
        state_d  = (learnEn_q && (~clampVal[15] != target_q)) ? UPD : DONE;
      end
      UPD: begin
        w1_d    = sat17(upd1Wide);
        w2_d    = sat17(upd2Wide);
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && input_write_i) overrun_d = 1'b1;

    if (state_q != IDLE && state_q != DONE && weight_write_i) begin
      pendValid_d = 1'b1;
      pendW1_d    = weight1_new_i;
      pendW2_d    = weight2_new_i;
    end

    // A deferred write lands on the edge into DONE so it is visible alongside result_valid
    // and wins over the learning update; a write during DONE itself loads directly.
    if ((state_d == DONE && state_q != DONE) || state_q == DONE) begin
      if (weight_write_i) begin
        w1_d = weight1_new_i;
        w2_d = weight2_new_i;
      end else if (pendValid_q) begin
        w1_d = pendW1_q;
        w2_d = pendW2_q;
      end
      pendValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      w1_q        <= '0;
      w2_q        <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      learnEn_q   <= 1'b0;
      target_q    <= 1'b0;
      prod1_q     <= '0;
      sum_q       <= '0;
      result_q    <= '0;
      act_q       <= 1'b0;
      overrun_q   <= 1'b0;
      pendValid_q <= 1'b0;
      pendW1_q    <= '0;
      pendW2_q    <= '0;
    end else begin
      state_q     <= state_d;
      w1_q        <= w1_d;
      w2_q        <= w2_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      learnEn_q   <= learnEn_d;
      target_q    <= target_d;
      prod1_q     <= prod1_d;
      sum_q       <= sum_d;
      result_q    <= result_d;
      act_q       <= act_d;
      overrun_q   <= overrun_d;
      pendValid_q <= pendValid_d;
      pendW1_q    <= pendW1_d;
      pendW2_q    <= pendW2_d;
    end
  end

  always_comb begin
    mul_a_o = '0;
    mul_b_o = '0;
    if (state_q == MUL1) begin
      mul_a_o = w1_q;
      mul_b_o = x1_q;
    end else if (state_q == MUL2) begin
      mul_a_o = w2_q;
      mul_b_o = x2_q;
    end
  end

  assign weight1_o      = w1_q;
  assign weight2_o      = w2_q;
  assign result_o       = result_q;
  assign activation_o   = act_q;
  assign result_valid_o = (state_q == DONE);
  assign busy_o         = (state_q != IDLE);
  assign overrun_o      = overrun_q;

endmodule

// File: doc/perceptron_sequencer.md
# perceptron_sequencer

Sequences the two-input perceptron datapath. It owns the weight and input registers and time-shares one external registered signed multiplier across the two products and the weighted sum. It applies the step activation and optionally performs one on-chip learning update per evaluation. It sits between the host communication controller (weight/input write strobes) and the shared multiplier, and returns `result` for host readback.

## Interface
- `FRAC_BITS`, 8: fractional bits of the signed Q-format for weights, inputs and result (Q8.8 at default).
- `RATE_SHIFT`, 2: learning rate as 2^-RATE_SHIFT; weight delta = x >>> RATE_SHIFT.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `weight_write` in 1: one-cycle strobe; load `weight1_new`/`weight2_new`.
- `weight1_new`, `weight2_new` in 16: signed new weights.
- `input_write` in 1: one-cycle strobe; load `data_in1`/`data_in2` and start an evaluation.
- `data_in1`, `data_in2` in 16: signed inputs.
- `learn_en` in 1: sampled with `input_write`; enables the update step.
- `target` in 1: sampled with `input_write`; desired activation.
- `mul_a`, `mul_b` out 16: multiplier operands.
- `mul_p` in 32: signed product of the operands driven in the previous cycle (latency 1).
- `weight1`, `weight2` out 16: current weights.
- `result` out 16: saturated weighted sum.
- `activation` out 1: step output, 1 when `result` ≥ 0.
- `result_valid` out 1: one-cycle pulse when an evaluation completes.
- `busy` out 1: high from the cycle after an accepted `input_write` through the DONE cycle.
- `overrun` out 1: sticky; an `input_write` arrived while busy.

## Operation
- States: IDLE, MUL1, MUL2, ACC, ACT, UPD, DONE.
- IDLE:
  - On `input_write`: latch x1, x2, `learn_en`, `target`; clear `overrun`; go to MUL1.
  - On `weight_write`: load the weights immediately.
  - If both strobes arrive in the same cycle, weights load first and the evaluation uses the new weights.
- MUL1: drive `mul_a`=w1, `mul_b`=x1.
- MUL2: drive w2, x2; capture p1 = `mul_p`.
- ACC: capture p2; sum = (p1 + p2) computed in 33 bits, then >>> FRAC_BITS.
- ACT:
  - `result` = sum clamped to [0x8000, 0x7FFF]; `activation` = ~result[15].
  - Go to UPD if `learn_en` and `activation`≠`target`, else go to DONE.
- UPD: apply the perceptron rule.
  - target=1: wi += xi >>> RATE_SHIFT.
  - target=0: wi −= xi >>> RATE_SHIFT.
  - Compute in 17 bits and saturate to 16 bits. Then go to DONE.
- DONE: pulse `result_valid`; apply any pending weight write; go to IDLE.
- `mul_a`/`mul_b` are 0 outside MUL1/MUL2.
- `weight_write` while busy: latch values and set a pending flag (a later write overwrites earlier ones). The pending write is applied in DONE and takes precedence over the UPD result.
- `input_write` while busy: ignored; set `overrun`.
- Reset mid-operation: return to IDLE immediately. Pending write, latched inputs and all outputs are cleared.

## Timing
- Reset values: `weight1`=`weight2`=`result`=0, `activation`=0, `result_valid`=0, `busy`=0, `mul_a`=`mul_b`=0, `overrun`=0.
- Take `input_write` in cycle 0:
  - MUL1 occupies cycle 1 and ACT occupies cycle 4.
  - Without update, `result_valid` pulses in cycle 5.
  - With update, UPD is cycle 5 and `result_valid` pulses in cycle 6.
- `result`/`activation` are updated at the end of ACT and hold until the next ACT.
- Weights written in UPD/DONE are visible in the same cycle as `result_valid`.
- A new `input_write` is accepted in the cycle `result_valid` is low and the state is IDLE, i.e. cycle 6 (or 7 with update) at the earliest.

## Test plan
- Basic evaluation: w1=0x0100, w2=0x0200, x1=0x0300, x2=0x0100, learn_en=0 → `result`=0x0500, `activation`=1, `result_valid` exactly in cycle 5, `busy` high for cycles 1–5.
- Saturation: all operands 0x7FFF → `result`=0x7FFF. Then w1=0x8000, x1=0x7FFF, w2=0 → `result`=0x8000, `activation`=0.
- Learning: w=0/0, x1=0x0100, x2=0xFF00, target=0, learn_en=1 → `activation`=1, `weight1`=0xFFC0, `weight2`=0x0040, `result_valid` in cycle 6. Repeat with target=1 → no update, valid in cycle 5.
- Deferred weight write: `weight_write` 0x0011/0x0022 in cycle 2 of a learning evaluation → product uses the old weights; in the DONE cycle weights become 0x0011/0x0022, overriding the UPD result.
- Overrun: `input_write` in cycle 3 → ignored, `overrun`=1, the original result is unchanged. The next accepted `input_write` clears `overrun`.
- Reset: assert `rst_n`=0 during MUL2 → all outputs return to their reset values and `result_valid` never pulses.
